// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: pattern modes and bounce direction.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_TO_LSB = 1'b0,
    DIR_TO_MSB = 1'b1
  } dir_e;

endpackage

// File: rtl/led_step_divider.sv
// Step-period divider: produces a tick once every period+1 enabled cycles.
// The compare is >= so that lowering period below the running count ticks at once.
module led_step_divider #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = enable && (count >= period);

  // Count enabled cycles, wrapping to zero on a tick; clear restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: steps a selectable LED pattern at a programmable rate,
// flagging each step and each completed pattern period with one-cycle pulses.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int LED_WIDTH = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] speed_div,
  output logic [LED_WIDTH-1:0] led_data,
  output logic                 step_tick,
  output logic                 cycle_done
);

  localparam logic [LED_WIDTH-1:0] LED_ONE = LED_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_MSB = LED_ONE << (LED_WIDTH - 1);
  localparam logic [LED_WIDTH-1:0] LED_ALL = '1;

  mode_e                mode_cur;
  mode_e                mode_q;
  dir_e                 dir_q;
  dir_e                 dir_next;
  logic                 restart_pending;
  logic                 tick;
  logic                 restart;
  logic                 advance;
  logic [LED_WIDTH-1:0] led_next;
  logic                 step_next;
  logic                 done_next;

  // Starting pattern loaded whenever a mode (re)starts.
  function automatic logic [LED_WIDTH-1:0] initial_pattern(input mode_e m);
    case (m)
      MODE_BOUNCE, MODE_ROTATE: return LED_MSB;
      MODE_FILL:                return '0;
      default:                  return LED_ALL;
    endcase
  endfunction

  assign mode_cur = mode_e'(mode);

  // A restart wins over a coincident divider tick.
  assign restart = enable && (restart_pending || (mode_q != mode_cur));
  assign advance = tick && !restart;

  led_step_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (restart),
    .period (speed_div),
    .tick   (tick)
  );

  // State register: pattern, direction, captured mode and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_data        <= '0;
      step_tick       <= 1'b0;
      cycle_done      <= 1'b0;
      dir_q           <= DIR_TO_LSB;
      mode_q          <= MODE_BOUNCE;
      restart_pending <= 1'b1;
    end else begin
      led_data   <= led_next;
      dir_q      <= dir_next;
      step_tick  <= step_next;
      cycle_done <= done_next;
      if (restart) begin
        mode_q          <= mode_cur;
        restart_pending <= 1'b0;
      end
    end
  end

  // Next pattern and direction for a restart or a step of the current mode.
  always_comb begin
    led_next = led_data;
    dir_next = dir_q;
    if (restart) begin
      led_next = initial_pattern(mode_cur);
      dir_next = DIR_TO_LSB;
    end else if (advance) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (LED_WIDTH == 1) begin
            led_next = LED_ONE;
          end else if (dir_q == DIR_TO_LSB) begin
            if (led_data[0]) begin
              led_next = led_data << 1;
              dir_next = DIR_TO_MSB;
            end else begin
              led_next = led_data >> 1;
            end
          end else begin
            if (led_data[LED_WIDTH-1]) begin
              led_next = led_data >> 1;
              dir_next = DIR_TO_LSB;
            end else begin
              led_next = led_data << 1;
            end
          end
        end
        MODE_ROTATE: led_next = (led_data >> 1) | (led_data << (LED_WIDTH - 1));
        MODE_FILL:   led_next = (led_data == LED_ALL) ? '0 : ((led_data >> 1) | LED_MSB);
        default:     led_next = ~led_data;
      endcase
    end
  end

  // Step and period-complete pulses, raised only for a genuine step.
  always_comb begin
    step_next = advance;
    done_next = 1'b0;
    if (advance) begin
      case (mode_q)
        MODE_BOUNCE: done_next = (led_next == LED_MSB);
        MODE_ROTATE: done_next = led_data[0];
        MODE_FILL:   done_next = (led_data == LED_ALL);
        default:     done_next = (led_data == '0);
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (8 LEDs): a phase-based pattern
// model is compared every cycle, and directed scenarios pin literal values.
module tb_led_pattern_engine;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] speed_div;
  logic [7:0] led_data;
  logic       step_tick;
  logic       cycle_done;

  int checks_total  = 0;
  int checks_passed = 0;
  bit checks_on     = 0;

  // Model state: pattern phase within its period plus the divider count.
  int         m_cnt;
  int         m_phase;
  logic       m_pending;
  logic [1:0] m_mode;
  logic [7:0] exp_led;
  logic       exp_step;
  logic       exp_done;

  logic [7:0] fill_seq [9] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};

  led_pattern_engine #(
    .LED_WIDTH(W),
    .DIV_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .speed_div  (speed_div),
    .led_data   (led_data),
    .step_tick  (step_tick),
    .cycle_done (cycle_done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int periodOf(input logic [1:0] md);
    case (md)
      2'd0:    return 2 * W - 2;
      2'd1:    return W;
      2'd2:    return W + 1;
      default: return 2;
    endcase
  endfunction

  // LED value at a given phase of a mode's period.
  function automatic logic [7:0] patternAt(input logic [1:0] md, input int p);
    logic [7:0] one;
    logic [7:0] all;
    int         pos;
    one = 8'h01;
    all = 8'hFF;
    case (md)
      2'd0: begin
        pos = (p <= W - 1) ? (W - 1 - p) : (p - (W - 1));
        return one << pos;
      end
      2'd1:    return one << (W - 1 - p);
      2'd2:    return (p == 0) ? 8'h00 : ~(all >> p);
      default: return (p == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic resetModel();
    m_pending = 1'b1;
    m_mode    = 2'd0;
    m_cnt     = 0;
    m_phase   = 0;
    exp_led   = 8'h00;
    exp_step  = 1'b0;
    exp_done  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] md, input logic [7:0] spd);
    enable    = en;
    mode      = md;
    speed_div = spd;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitForLed(input logic [7:0] target, input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      nextCycle();
      if (led_data == target) break;
    end
    checkOutput(name, led_data, target);
  endtask

  task automatic waitForStep(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      nextCycle();
      if (step_tick) break;
    end
    checkOutput(name, step_tick, 1);
  endtask

  // Behavioural model advanced on each clock edge, reset asynchronously.
  initial begin
    resetModel();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        resetModel();
      end else if (enable) begin
        if (m_pending || (m_mode != mode)) begin
          m_pending = 1'b0;
          m_mode    = mode;
          m_phase   = 0;
          m_cnt     = 0;
          exp_led   = patternAt(mode, 0);
          exp_step  = 1'b0;
          exp_done  = 1'b0;
        end else if (m_cnt >= int'(speed_div)) begin
          m_cnt    = 0;
          m_phase  = (m_phase + 1) % periodOf(m_mode);
          exp_led  = patternAt(m_mode, m_phase);
          exp_step = 1'b1;
          exp_done = (m_phase == 0);
        end else begin
          m_cnt++;
          exp_step = 1'b0;
          exp_done = 1'b0;
        end
      end else begin
        exp_step = 1'b0;
        exp_done = 1'b0;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (checks_on) begin
      checkOutput("model_led", led_data, exp_led);
      checkOutput("model_step", step_tick, exp_step);
      checkOutput("model_done", cycle_done, exp_done);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int steps;
    int dones;
    logic [7:0] done_led;

    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'd3);
    repeat (3) nextCycle();
    checkOutput("reset_led", led_data, 8'h00);
    checkOutput("reset_step", step_tick, 0);
    checkOutput("reset_done", cycle_done, 0);

    // Bounce at speed 3 from reset.
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd0, 8'd3);
    checks_on = 1;
    nextCycle();
    checkOutput("bounce_restart_led", led_data, 8'h80);
    checkOutput("bounce_restart_step", step_tick, 0);
    steps = 0;
    dones = 0;
    done_led = 8'h00;
    for (int i = 1; i <= 56; i++) begin
      nextCycle();
      if (i == 4) checkOutput("bounce_first_step", led_data, 8'h40);
      if (step_tick) steps++;
      if (cycle_done) begin
        dones++;
        done_led = led_data;
      end
    end
    checkOutput("bounce_step_count", steps, 14);
    checkOutput("bounce_done_count", dones, 1);
    checkOutput("bounce_done_led", done_led, 8'h80);

    // Switch to blink while bouncing at 10.
    waitForLed(8'h10, 40, "bounce_reach_10");
    applyStimulus(1'b1, 2'd3, 8'd3);
    nextCycle();
    checkOutput("blink_restart_led", led_data, 8'hFF);
    checkOutput("blink_restart_step", step_tick, 0);
    repeat (3) nextCycle();
    checkOutput("blink_hold_led", led_data, 8'hFF);
    nextCycle();
    checkOutput("blink_first_led", led_data, 8'h00);
    checkOutput("blink_first_step", step_tick, 1);

    // Fill at full speed.
    applyStimulus(1'b1, 2'd2, 8'd0);
    nextCycle();
    checkOutput("fill_restart_led", led_data, 8'h00);
    checkOutput("fill_restart_step", step_tick, 0);
    for (int i = 0; i < 9; i++) begin
      nextCycle();
      checkOutput("fill_seq_led", led_data, fill_seq[i]);
      checkOutput("fill_seq_step", step_tick, 1);
      checkOutput("fill_seq_done", cycle_done, (i == 8) ? 1 : 0);
    end

    // Reset pulse mid-fill at E0.
    waitForLed(8'hE0, 20, "fill_reach_E0");
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_led", led_data, 8'h00);
    checkOutput("async_reset_step", step_tick, 0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd2, 8'd2);
    nextCycle();
    checkOutput("fill_rerestart_led", led_data, 8'h00);
    repeat (2) nextCycle();
    checkOutput("fill_rerestart_hold", led_data, 8'h00);
    nextCycle();
    checkOutput("fill_rerestart_step_led", led_data, 8'h80);

    // Rotate, freeze at 08 for 20 cycles, then resume.
    applyStimulus(1'b1, 2'd1, 8'd3);
    waitForLed(8'h08, 40, "rotate_reach_08");
    nextCycle();
    applyStimulus(1'b0, 2'd1, 8'd3);
    repeat (20) nextCycle();
    checkOutput("freeze_led", led_data, 8'h08);
    checkOutput("freeze_step", step_tick, 0);
    applyStimulus(1'b1, 2'd1, 8'd3);
    repeat (2) nextCycle();
    checkOutput("resume_hold_led", led_data, 8'h08);
    nextCycle();
    checkOutput("resume_step_led", led_data, 8'h04);
    checkOutput("resume_step_tick", step_tick, 1);

    // Lower speed_div from 100 to 2 with the count at 50.
    applyStimulus(1'b1, 2'd1, 8'd100);
    waitForStep(250, "slow_step_seen");
    repeat (50) nextCycle();
    applyStimulus(1'b1, 2'd1, 8'd2);
    nextCycle();
    checkOutput("speed_drop_tick", step_tick, 1);
    nextCycle();
    checkOutput("speed_gap1", step_tick, 0);
    nextCycle();
    checkOutput("speed_gap2", step_tick, 0);
    nextCycle();
    checkOutput("speed_next_tick", step_tick, 1);

    checks_on = 0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameter LED_WIDTH, default 8: number of LED outputs; legal range 1..32.
REQ-002 Parameter DIV_WIDTH, default 24: width of the step-period divider.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  1 = pattern advances; 0 = freeze divider, pattern and outputs.
REQ-006 mode  input  2  pattern select: 0 bounce, 1 rotate, 2 fill, 3 blink.
REQ-007 speed_div  input  DIV_WIDTH  step period = speed_div+1 clk cycles.
REQ-008 led_data  output  LED_WIDTH  registered LED pattern.
REQ-009 step_tick  output  1  registered one-cycle pulse, coincident with each led_data step update.
REQ-010 cycle_done  output  1  registered one-cycle pulse, coincident with the step that completes a full pattern period.

Function
REQ-011 Divider counts 0..speed_div while enable=1; tick in the cycle where count >= speed_div, count clears on that edge; speed_div=0 gives a tick every enabled cycle.
REQ-012 speed_div is sampled live; lowering it below the current count causes a tick on the next enabled cycle (>= compare); no wait for wrap.
REQ-013 On the edge ending a tick cycle: led_data steps, step_tick=1 for the following cycle; otherwise step_tick=0.
REQ-014 Restart event (first enabled cycle after reset, or registered mode_q != mode): divider cleared, led_data loaded with the mode's initial pattern on that edge, direction = toward LSB, no step_tick, no cycle_done; mode_q <= mode.
REQ-015 Restart has priority over a coincident tick.
REQ-016 Bounce: initial one-hot MSB; each tick moves one bit toward LSB, reverses at bit 0, moves toward MSB, reverses at MSB; period 2*LED_WIDTH-2 ticks; cycle_done on the tick that returns to MSB.
REQ-017 Rotate: initial one-hot MSB; each tick rotates right, bit 0 wraps to MSB; period LED_WIDTH ticks; cycle_done on the wrap tick.
REQ-018 Fill: initial all-zero; each tick shifts a 1 in from MSB ({1,led[W-1:1]}); tick after all-ones clears to all-zero; period LED_WIDTH+1; cycle_done on the clear tick.
REQ-019 Blink: initial all-ones; each tick inverts all bits; period 2; cycle_done on the tick returning to all-ones.
REQ-020 LED_WIDTH=1: bounce and rotate hold 1'b1, cycle_done on every tick.
REQ-021 enable=0: divider, pattern, direction and mode_q hold; step_tick and cycle_done forced 0; mode changes are detected once enable returns to 1.

Reset
REQ-022 rst_n low asynchronously clears led_data=0, step_tick=0, cycle_done=0, divider=0, direction=toward LSB, mode_q=0, and sets the pending-restart flag.
REQ-023 Reset asserted mid-pattern aborts immediately; after release the pattern resumes from the initial value of the current mode per REQ-014.

Structure
REQ-024 Package led_pattern_pkg holds the mode encoding constants (MODE_BOUNCE=0, MODE_ROTATE=1, MODE_FILL=2, MODE_BLINK=3).
REQ-025 Divider in sub-module led_step_divider (ports clk, rst_n, enable, clear, period, tick); pattern state machine in the top level.

Verification
REQ-026 W=8, mode=0, speed_div=3, enable=1 after reset -> led 80 on restart, then 40,20,...,01,02,...,40,80, each step 4 cycles apart; cycle_done once per 14 steps, with 80.
REQ-027 mode=2, speed_div=0 -> 00,80,C0,...,FF,00 on consecutive cycles; cycle_done with the 00 after FF.
REQ-028 Bounce mid-run at 10, switch mode to 3 -> next edge led=FF, no step_tick, divider restarted; then 00 after speed_div+1 cycles.
REQ-029 enable=0 for 20 cycles mid-rotate at 08 -> led stays 08, step_tick stays 0; resume -> 04 after remaining divider count.
REQ-030 speed_div changed 100 -> 2 while count=50 -> tick on next cycle, then every 3 cycles.
REQ-031 rst_n pulsed low mid-fill at E0 -> led=00 immediately; after release restart to 00 then 80 after speed_div+1 cycles.
